// File: rtl/vga_pkg.sv
// Shared VGA pixel types, colour defaults and glyph geometry.
package vga_pkg;

  localparam int HV_W    = 10;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BG   = 24'hf8f9fa;
  localparam rgb_t RGB_TEXT = 24'h343a40;

  // log2 of the legal replication factors; anything else maps to -1.
  function automatic int scale_shift(input int scale);
    case (scale)
      1:       return 0;
      2:       return 1;
      4:       return 2;
      8:       return 3;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame counter that toggles the blink phase every FRAMES frame_start pulses.
module blink_timer #(
  parameter int FRAMES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  output logic phase_o
);

  localparam int CW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start_i) begin
      if (cnt_q == CW'(FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/glyph_renderer.sv
// Three-stage text-box renderer: text-buffer lookup, font-ROM lookup, pixel colour.
module glyph_renderer
  import vga_pkg::*;
#(
  parameter int   X_START      = 300,
  parameter int   Y_START      = 400,
  parameter int   NCHARS       = 8,
  parameter int   SCALE        = 2,
  parameter int   BLINK_FRAMES = 32,
  parameter rgb_t RGB_BG       = vga_pkg::RGB_BG,
  parameter rgb_t RGB_TEXT     = vga_pkg::RGB_TEXT,
  localparam int  IDX_W        = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bright_i,
  input  logic             frame_start_i,
  input  logic             blink_en_i,
  input  logic             invert_i,
  input  logic [HV_W-1:0]  hcount_i,
  input  logic [HV_W-1:0]  vcount_i,
  output logic [IDX_W-1:0] char_idx_o,
  input  logic [7:0]       char_code_i,
  output logic [7:0]       glyph_code_o,
  output logic [2:0]       glyph_row_o,
  input  logic [7:0]       glyph_bits_i,
  output rgb_t             rgb_o,
  output logic             in_box_o
);

  localparam int SHIFT = scale_shift(SCALE);
  localparam int X_END = X_START + NCHARS * GLYPH_W * SCALE;
  localparam int Y_END = Y_START + GLYPH_H * SCALE;

  generate
    if (SHIFT < 0 || X_END > 1024 || Y_END > 1024 || NCHARS < 1 || NCHARS > 64 ||
        BLINK_FRAMES < 2) begin : g_bad_params
      $error("glyph_renderer: illegal SCALE/NCHARS/BLINK_FRAMES or box exceeds 1024");
    end
  endgenerate

  localparam logic [10:0] X_LO = 11'(X_START);
  localparam logic [10:0] X_HI = 11'(X_END);
  localparam logic [10:0] Y_LO = 11'(Y_START);
  localparam logic [10:0] Y_HI = 11'(Y_END);

  logic [10:0]      h_ext, v_ext, dx_s0, dy_s0;
  logic             hit_s0;
  logic [IDX_W-1:0] idx_s0;

  assign h_ext  = {1'b0, hcount_i};
  assign v_ext  = {1'b0, vcount_i};
  assign hit_s0 = (h_ext >= X_LO) && (h_ext < X_HI) && (v_ext >= Y_LO) && (v_ext < Y_HI);
  assign dx_s0  = h_ext - X_LO;
  assign dy_s0  = v_ext - Y_LO;
  assign idx_s0 = IDX_W'(dx_s0 >> (SHIFT + 3));

  // Buffer addresses are presented combinationally so each external memory's
  // one-cycle latency lines up with the next stage register; outside the box
  // they fall back to the held copies.
  logic [10:0]      dx_q, dy_q;
  logic             hit1_q, bright1_q;
  logic [IDX_W-1:0] char_idx_q;
  logic [2:0]       col1, row1;

  assign char_idx_o = (rst_n && hit_s0) ? idx_s0 : char_idx_q;
  assign col1       = 3'(dx_q >> SHIFT);
  assign row1       = 3'(dy_q >> SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q       <= '0;
      dy_q       <= '0;
      hit1_q     <= 1'b0;
      bright1_q  <= 1'b0;
      char_idx_q <= '0;
    end else begin
      dx_q       <= dx_s0;
      dy_q       <= dy_s0;
      hit1_q     <= hit_s0;
      bright1_q  <= bright_i;
      char_idx_q <= char_idx_o;
    end
  end

  logic [7:0] glyph_code_q;
  logic [2:0] glyph_row_q, col2_q;
  logic       hit2_q, bright2_q;

  assign glyph_code_o = hit1_q ? char_code_i : glyph_code_q;
  assign glyph_row_o  = hit1_q ? row1        : glyph_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_code_q <= '0;
      glyph_row_q  <= '0;
      col2_q       <= '0;
      hit2_q       <= 1'b0;
      bright2_q    <= 1'b0;
    end else begin
      glyph_code_q <= glyph_code_o;
      glyph_row_q  <= glyph_row_o;
      col2_q       <= col1;
      hit2_q       <= hit1_q;
      bright2_q    <= bright1_q;
    end
  end

  logic blink_phase;

  blink_timer #(.FRAMES(BLINK_FRAMES)) u_blink (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .phase_o       (blink_phase)
  );

  logic pix, show;
  rgb_t rgb_d, rgb_q;
  logic in_box_d, in_box_q;

  always_comb begin
    pix      = glyph_bits_i[col2_q] & ~(blink_en_i & blink_phase);
    show     = hit2_q & bright2_q;
    in_box_d = show;
    rgb_d    = RGB_BG;
    if (show && (pix ^ invert_i)) rgb_d = RGB_TEXT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= RGB_BG;
      in_box_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      in_box_q <= in_box_d;
    end
  end

  assign rgb_o    = rgb_q;
  assign in_box_o = in_box_q;

endmodule

// File: tb/tb_glyph_renderer.sv
// Randomized bench for glyph_renderer at SCALE=2 and SCALE=1 against a pixel-level model.
module tb_glyph_renderer;

  localparam logic [23:0] BG   = 24'hf8f9fa;
  localparam logic [23:0] TEXT = 24'h343a40;
  localparam int BF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, bright, frame_start, blink_en, invert;
  logic [9:0] hcount, vcount;

  logic [2:0]  char_idx_a, char_idx_b;
  logic [7:0]  code_a, code_b, bits_a, bits_b;
  logic [7:0]  glyph_code_a, glyph_code_b;
  logic [2:0]  glyph_row_a, glyph_row_b;
  logic [23:0] rgb_a, rgb_b;
  logic        in_box_a, in_box_b;

  glyph_renderer #(.SCALE(2), .BLINK_FRAMES(BF)) dut_a (
    .clk(clk), .rst_n(rst_n), .bright_i(bright), .frame_start_i(frame_start),
    .blink_en_i(blink_en), .invert_i(invert), .hcount_i(hcount), .vcount_i(vcount),
    .char_idx_o(char_idx_a), .char_code_i(code_a), .glyph_code_o(glyph_code_a),
    .glyph_row_o(glyph_row_a), .glyph_bits_i(bits_a), .rgb_o(rgb_a), .in_box_o(in_box_a)
  );

  glyph_renderer #(.SCALE(1), .BLINK_FRAMES(BF)) dut_b (
    .clk(clk), .rst_n(rst_n), .bright_i(bright), .frame_start_i(frame_start),
    .blink_en_i(blink_en), .invert_i(invert), .hcount_i(hcount), .vcount_i(vcount),
    .char_idx_o(char_idx_b), .char_code_i(code_b), .glyph_code_o(glyph_code_b),
    .glyph_row_o(glyph_row_b), .glyph_bits_i(bits_b), .rgb_o(rgb_b), .in_box_o(in_box_b)
  );

  // External text buffer and font ROM, one-cycle read latency.
  logic [7:0] text [0:7];
  logic [7:0] font [0:2047];

  always @(posedge clk) begin
    code_a <= text[char_idx_a];
    code_b <= text[char_idx_b];
    bits_a <= font[{glyph_code_a, glyph_row_a}];
    bits_b <= font[{glyph_code_b, glyph_row_b}];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    bit          hit;
    int          ci;
    int          row;
    logic [23:0] rgb;
    bit          inb;
  } exp_t;

  exp_t qa[$], qb[$];
  int   frames;
  int   ma_ci, ma_gc, ma_gr, mb_ci, mb_gc, mb_gr;

  // What a pixel at (h,v) should look like for replication factor s.
  function automatic exp_t model(input int h, input int v, input int s);
    exp_t e;
    int dx, col;
    logic [7:0] gbits;
    bit pix;
    e.hit = (h >= 300) && (h < 300 + 64 * s) && (v >= 400) && (v < 400 + 8 * s);
    e.ci = 0; e.row = 0; e.inb = e.hit && bright; e.rgb = BG;
    if (e.hit) begin
      dx    = h - 300;
      e.ci  = dx / (8 * s);
      col   = (dx / s) % 8;
      e.row = (v - 400) / s;
      gbits = font[int'(text[e.ci]) * 8 + e.row];
      pix   = gbits[col] && !(blink_en && ((frames / BF) % 2 == 1));
      if (e.inb && (pix ^ invert)) e.rgb = TEXT;
    end
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e.hit = 0; e.ci = 0; e.row = 0; e.rgb = BG; e.inb = 0;
    return e;
  endfunction

  task automatic reset_model();
    frames = 0;
    ma_ci = 0; ma_gc = 0; ma_gr = 0; mb_ci = 0; mb_gc = 0; mb_gr = 0;
    qa.delete(); qb.delete();
    repeat (3) begin qa.push_back(idle_e()); qb.push_back(idle_e()); end
  endtask

  task automatic step(input int h, input int v, input bit fs);
    hcount = 10'(h); vcount = 10'(v); frame_start = fs;
    qa.push_front(model(h, v, 2));
    qb.push_front(model(h, v, 1));
    @(posedge clk); #1;
    frame_start = 1'b0;
    if (fs) frames++;
    if (qa[0].hit) begin ma_ci = qa[0].ci; ma_gc = int'(text[qa[0].ci]); ma_gr = qa[0].row; end
    if (qb[0].hit) begin mb_ci = qb[0].ci; mb_gc = int'(text[qb[0].ci]); mb_gr = qb[0].row; end
    check("a_char_idx",   32'(char_idx_a),   32'(ma_ci));
    check("a_glyph_code", 32'(glyph_code_a), 32'(ma_gc));
    check("a_glyph_row",  32'(glyph_row_a),  32'(ma_gr));
    check("a_rgb",        32'(rgb_a),        32'(qa[2].rgb));
    check("a_in_box",     32'(in_box_a),     32'(qa[2].inb));
    check("b_char_idx",   32'(char_idx_b),   32'(mb_ci));
    check("b_glyph_code", 32'(glyph_code_b), 32'(mb_gc));
    check("b_glyph_row",  32'(glyph_row_b),  32'(mb_gr));
    check("b_rgb",        32'(rgb_b),        32'(qb[2].rgb));
    check("b_in_box",     32'(in_box_b),     32'(qb[2].inb));
    $display("px h=%0d v=%0d fs=%0d rgb_a=%h box_a=%0d rgb_b=%h box_b=%0d",
             h, v, fs, rgb_a, in_box_a, rgb_b, in_box_b);
    void'(qa.pop_back());
    void'(qb.pop_back());
  endtask

  task automatic flush();
    repeat (3) step(0, 0, 1'b0);
  endtask

  task automatic frame_pulses(input int n);
    flush();
    repeat (n) step(0, 0, 1'b1);
  endtask

  task automatic fill_random();
    foreach (text[i]) text[i] = 8'($urandom);
    foreach (font[i]) font[i] = 8'($urandom);
  endtask

  task automatic fill_font(input logic [7:0] val);
    foreach (font[i]) font[i] = val;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; bright = 1'b0; frame_start = 1'b0; blink_en = 1'b0; invert = 1'b0;
    hcount = 10'd310; vcount = 10'd405;
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb",      32'(rgb_a),        32'(BG));
    check("rst_in_box",   32'(in_box_a),     32'd0);
    check("rst_char_idx", 32'(char_idx_a),   32'd0);
    check("rst_gcode",    32'(glyph_code_a), 32'd0);
    rst_n = 1'b1;
    reset_model();

    // First-character geometry and column bit order.
    $display("scenario: first glyph");
    bright = 1'b1;
    text[0] = 8'h41;
    font[8'h41 * 8] = 8'h01;
    step(300, 400, 1'b0);
    step(302, 400, 1'b0);
    flush();

    $display("scenario: box edges");
    step(316, 400, 1'b0);
    step(427, 415, 1'b0);
    step(428, 400, 1'b0);
    step(300, 416, 1'b0);
    step(299, 405, 1'b0);
    step(363, 407, 1'b0);
    step(364, 407, 1'b0);
    flush();

    for (int blk = 0; blk < 4; blk++) begin
      $display("scenario: random block %0d", blk);
      flush();
      fill_random();
      invert   = 1'($urandom_range(0, 1));
      blink_en = 1'($urandom_range(0, 1));
      frame_pulses($urandom_range(0, 5));
      for (int i = 0; i < 60; i++) begin
        bright = ($urandom_range(0, 7) != 0);
        step($urandom_range(290, 440), $urandom_range(395, 420), 1'b0);
      end
    end
    flush();

    // Reset asserted with a lit in-box pixel in flight.
    $display("scenario: async reset mid-box");
    invert = 1'b0; blink_en = 1'b0; bright = 1'b1;
    fill_font(8'hff);
    step(310, 405, 1'b0);
    step(312, 405, 1'b0);
    step(314, 405, 1'b0);
    step(316, 405, 1'b0);
    check("pre_rst_rgb", 32'(rgb_a), 32'(TEXT));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rgb",    32'(rgb_a),        32'(BG));
    check("async_rst_in_box", 32'(in_box_a),     32'd0);
    check("async_rst_idx",    32'(char_idx_a),   32'd0);
    check("async_rst_gcode",  32'(glyph_code_a), 32'd0);
    check("async_rst_grow",   32'(glyph_row_a),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    repeat (4) step(318, 405, 1'b0);

    $display("scenario: blink");
    blink_en = 1'b1;
    step(310, 405, 1'b0);
    frame_pulses(BF);
    step(310, 405, 1'b0);
    step(330, 401, 1'b0);
    frame_pulses(BF);
    step(310, 405, 1'b0);
    step(330, 401, 1'b0);
    flush();

    $display("scenario: invert and bright");
    blink_en = 1'b0; invert = 1'b1;
    fill_font(8'h00);
    step(320, 404, 1'b0);
    bright = 1'b0;
    step(320, 404, 1'b0);
    flush();
    invert = 1'b0; bright = 1'b1;

    $display("scenario: unit scale last row");
    fill_random();
    text[0] = 8'h41;
    font[8'h41 * 8 + 7] = 8'h80;
    step(307, 407, 1'b0);
    step(306, 407, 1'b0);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
